poci_regfile: RTL and testbench
===============================

POCI_REGFILE -- requirements
Module: poci_regfile

Interface
REQ-001 Parameter NREG, 16, number of read/write config registers (1..64).
REQ-002 Parameter BASE_ADDR, 8'h01, address of config register 0; address 8'h00 is never a register.
REQ-003 Parameter CHIP_ID, 8'hA5, value returned at address 8'hFF.
REQ-004 sclk  input  1  SPI clock; all state on posedge sclk.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 addr  input  8  current register address from the address-pointer stage.
REQ-007 wdata  input  8  byte to write.
REQ-008 wr_en  input  1  one-sclk-cycle write strobe; wdata and addr are valid when it is high.
REQ-009 byte_start  input  1  high for the sclk cycle that begins an outgoing byte.
REQ-010 poci  output  1  serial read data, MSB first.
REQ-011 busy  output  1  high while a byte is being shifted out.
REQ-012 wr_err  output  1  sticky flag for a write to a non-writable address.
REQ-013 regs_flat  output  8*NREG  config register contents; register k at bits [8k+7:8k].

Function
REQ-014 Address decode SHALL be: BASE_ADDR..BASE_ADDR+NREG-1 = config reg (addr-BASE_ADDR), read/write; 8'hFE = write counter, read-only; 8'hFF = CHIP_ID, read-only; all other addresses unmapped.
REQ-015 On posedge sclk with wr_en=1 and addr mapping to a config reg, that reg SHALL take wdata; the update is visible on regs_flat after that edge.
REQ-016 On a write to a config reg, the 8-bit write counter SHALL increment by 1, wrapping 8'hFF -> 8'h00.
REQ-017 A wr_en=1 write to a read-only or unmapped address SHALL change no register or counter and SHALL set wr_err to 1.
REQ-018 wr_err SHALL stay 1 until rstn is asserted.
REQ-019 Read data SHALL be: config reg value, counter value, or CHIP_ID, as mapped; unmapped addresses read 8'h00.
REQ-020 The shifter FSM SHALL have two states, IDLE and SHIFT, with a 3-bit bit counter and an 8-bit shift register.
REQ-021 On posedge sclk with byte_start=1 (in either state):
  - shift register <= read data for the current addr;
  - bit counter <= 7;
  - state <= SHIFT.
REQ-022 In SHIFT with byte_start=0, each posedge SHALL:
  - shift the register left, filling with 0;
  - decrement the bit counter.
  When the counter is 0 at the edge, state SHALL go to IDLE.
REQ-023 poci SHALL equal shift register bit 7 in SHIFT and 0 in IDLE; the first bit is valid right after the loading edge, and 8 bits leave over 8 cycles.
REQ-024 busy SHALL be 1 exactly when state = SHIFT.
REQ-025 byte_start during SHIFT SHALL abort the current byte and reload per REQ-021 (restart wins).
REQ-026 If wr_en and byte_start are both high on the same edge and target the same address, the loaded read data SHALL be the pre-write value; the write still completes.
REQ-027 A write to the same config register in back-to-back cycles SHALL leave the second value; the counter SHALL increment twice.

Reset
REQ-028 While rstn=0, asynchronously:
  - config registers = 8'h00;
  - write counter = 8'h00;
  - wr_err = 0;
  - state = IDLE, shift register = 0, bit counter = 0;
  - poci = 0, busy = 0.
REQ-029 Reset asserted mid-shift SHALL force poci=0 and busy=0 immediately, without waiting for a clock edge.
REQ-030 After rstn deasserts, the first posedge SHALL operate normally.

Verification
REQ-031 Write 8'h3C to addr 8'h01, then byte_start with addr 8'h01. Required:
  - regs_flat[7:0] = 8'h3C;
  - poci sequence over 8 cycles = 0,0,1,1,1,1,0,0;
  - busy high exactly 8 cycles.
REQ-032 byte_start at addr 8'hFF. Required: poci = 1,0,1,0,0,1,0,1; write to 8'hFF sets wr_err=1 and CHIP_ID is unchanged.
REQ-033 Perform 257 writes to config regs, then read 8'hFE. Required: value 8'h01 (counter wrapped).
REQ-034 Write to addr 8'h00 and to addr 8'h40 (unmapped with NREG=16). Required: no regs_flat change; wr_err=1; reads of 8'h40 return 8'h00.
REQ-035 Reg 8'h02 holds 8'hAA; wr_en (wdata 8'h55) and byte_start at addr 8'h02 on the same edge. Required: shifted byte = 8'hAA; regs_flat[15:8] = 8'h55 afterwards.
REQ-036 Reset mid-shift: assert rstn=0 after 3 shifted bits. Required:
  - poci=0 and busy=0 immediately;
  - all regs 8'h00;
  - a new byte_start then shifts the correct fresh data.

Source files
------------

// File: rtl/poci_regfile.sv
// Config register file with write counter and chip ID, read out MSB-first on poci
// through a two-state byte shifter clocked by the SPI clock.
module poci_regfile #(
    parameter int         NREG      = 16,
    parameter logic [7:0] BASE_ADDR = 8'h01,
    parameter logic [7:0] CHIP_ID   = 8'hA5
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic [7:0]        addr,
    input  logic [7:0]        wdata,
    input  logic              wr_en,
    input  logic              byte_start,
    output logic              poci,
    output logic              busy,
    output logic              wr_err,
    output logic [8*NREG-1:0] regs_flat
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_ADDR = 8'hFE;
    localparam logic [7:0] ID_ADDR  = 8'hFF;

    logic [7:0] regs_q [NREG];
    logic [7:0] regs_d [NREG];
    logic [7:0] wrCnt_q, wrCnt_d;
    logic       wrErr_q, wrErr_d;
    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bitCnt_q, bitCnt_d;

    logic       isId, isCnt, cfgHit;
    logic [8:0] cfgOff;
    logic [7:0] rdata;

    // Read-only addresses take priority so a large BASE_ADDR/NREG can never shadow them.
    assign isId   = (addr == ID_ADDR);
    assign isCnt  = (addr == CNT_ADDR);
    assign cfgOff = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign cfgHit = (addr >= BASE_ADDR) && (cfgOff < 9'(NREG)) && !isId && !isCnt;

    always_comb begin
        rdata = 8'h00;
        if (isId) begin
            rdata = CHIP_ID;
        end else if (isCnt) begin
            rdata = wrCnt_q;
        end else if (cfgHit) begin
            for (int k = 0; k < NREG; k++) begin
                if (cfgOff == 9'(k)) rdata = regs_q[k];
            end
        end
    end

    always_comb begin
        regs_d  = regs_q;
        wrCnt_d = wrCnt_q;
        wrErr_d = wrErr_q;
        if (wr_en) begin
            if (cfgHit) begin
                for (int k = 0; k < NREG; k++) begin
                    if (cfgOff == 9'(k)) regs_d[k] = wdata;
                end
                wrCnt_d = wrCnt_q + 8'd1;
            end else begin
                wrErr_d = 1'b1;
            end
        end
    end

    // rdata comes from the current register state, so a same-edge write is not seen by the load.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitCnt_d = bitCnt_q;
        if (byte_start) begin
            shift_d  = rdata;
            bitCnt_d = 3'd7;
            state_d  = SHIFT;
        end else if (state_q == SHIFT) begin
            shift_d  = {shift_q[6:0], 1'b0};
            bitCnt_d = bitCnt_q - 3'd1;
            if (bitCnt_q == 3'd0) begin
                bitCnt_d = 3'd0;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= 8'h00;
            wrCnt_q  <= 8'h00;
            wrErr_q  <= 1'b0;
            state_q  <= IDLE;
            shift_q  <= 8'h00;
            bitCnt_q <= 3'd0;
        end else begin
            regs_q   <= regs_d;
            wrCnt_q  <= wrCnt_d;
            wrErr_q  <= wrErr_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign poci   = busy & shift_q[7];
    assign wr_err = wrErr_q;

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = regs_q[k];
    end

endmodule

// File: tb/tb_poci_regfile.sv
// Self-checking bench for poci_regfile: table of write/read vectors plus hand-built
// sequences for wrap, same-edge, restart and reset-mid-shift cases.
module tb_poci_regfile;

    logic         sclk = 1'b0;
    logic         rstn;
    logic [7:0]   addr, wdata;
    logic         wr_en, byte_start;
    logic         poci, busy, wr_err;
    logic [127:0] regs_flat;

    int checks = 0;
    int errors = 0;
    logic         expBits[$];
    logic [127:0] expFlat;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       doWr;
        logic [7:0] expRead;
        logic       expErr;
        string      name;
    } vec_t;

    vec_t vecs[8];

    poci_regfile dut (
        .sclk       (sclk),
        .rstn       (rstn),
        .addr       (addr),
        .wdata      (wdata),
        .wr_en      (wr_en),
        .byte_start (byte_start),
        .poci       (poci),
        .busy       (busy),
        .wr_err     (wr_err),
        .regs_flat  (regs_flat)
    );

    always #5 sclk = ~sclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic applyStimulus(input logic doWr, input logic [7:0] a, input logic [7:0] d,
                                 input logic doStart);
        addr       = a;
        wdata      = d;
        wr_en      = doWr;
        byte_start = doStart;
        tick();
        wr_en      = 1'b0;
        byte_start = 1'b0;
    endtask

    task automatic doReset();
        rstn       = 1'b0;
        wr_en      = 1'b0;
        byte_start = 1'b0;
        addr       = 8'h00;
        wdata      = 8'h00;
        expFlat    = '0;
        expBits.delete();
        repeat (2) @(negedge sclk);
        rstn = 1'b1;
    endtask

    task automatic modelWrite(input logic [7:0] a, input logic [7:0] d);
        if (a >= 8'h01 && a <= 8'h10) expFlat[8*(int'(a)-1) +: 8] = d;
    endtask

    task automatic startByte(input logic [7:0] a, input logic [7:0] expByte);
        for (int i = 7; i >= 0; i--) expBits.push_back(expByte[i]);
        applyStimulus(1'b0, a, 8'h00, 1'b1);
    endtask

    task automatic checkBits(input string name, input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            if (expBits.size() == 0) begin
                checkOutput({name, " scoreboard empty"}, 128'(1), 128'(0));
            end else begin
                e = expBits.pop_front();
                checkOutput({name, " poci"}, 128'(poci), 128'(e));
                checkOutput({name, " busy"}, 128'(busy), 128'(1));
            end
            if (i != n - 1) tick();
        end
    endtask

    task automatic readByte(input logic [7:0] a, input logic [7:0] expByte, input string name);
        startByte(a, expByte);
        checkBits(name, 8);
        tick();
        checkOutput({name, " busy after byte"}, 128'(busy), 128'(0));
        checkOutput({name, " poci after byte"}, 128'(poci), 128'(0));
    endtask

    task automatic setVec(input int i, input logic doWr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] expRead, input logic expErr, input string name);
        vecs[i].doWr    = doWr;
        vecs[i].addr    = a;
        vecs[i].wdata   = d;
        vecs[i].expRead = expRead;
        vecs[i].expErr  = expErr;
        vecs[i].name    = name;
    endtask

    initial begin
        setVec(0, 1'b1, 8'h01, 8'h3C, 8'h3C, 1'b0, "reg0 3C");
        setVec(1, 1'b1, 8'h02, 8'hAA, 8'hAA, 1'b0, "reg1 AA");
        setVec(2, 1'b1, 8'h10, 8'h81, 8'h81, 1'b0, "reg15 81");
        setVec(3, 1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0, "chip id");
        setVec(4, 1'b0, 8'hFE, 8'h00, 8'h03, 1'b0, "counter 3");
        setVec(5, 1'b1, 8'h11, 8'h77, 8'h00, 1'b1, "past last reg");
        setVec(6, 1'b0, 8'hFE, 8'h00, 8'h03, 1'b1, "counter unchanged");
        setVec(7, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, "addr 00 read");

        doReset();
        checkOutput("reset regs_flat", regs_flat, '0);
        checkOutput("reset poci", 128'(poci), 128'(0));
        checkOutput("reset busy", 128'(busy), 128'(0));
        checkOutput("reset wr_err", 128'(wr_err), 128'(0));

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].doWr) begin
                applyStimulus(1'b1, vecs[i].addr, vecs[i].wdata, 1'b0);
                modelWrite(vecs[i].addr, vecs[i].wdata);
            end
            readByte(vecs[i].addr, vecs[i].expRead, vecs[i].name);
            checkOutput({vecs[i].name, " regs_flat"}, regs_flat, expFlat);
            checkOutput({vecs[i].name, " wr_err"}, 128'(wr_err), 128'(vecs[i].expErr));
        end

        // Write to CHIP_ID location is rejected and flagged.
        doReset();
        applyStimulus(1'b1, 8'hFF, 8'h12, 1'b0);
        checkOutput("id write wr_err", 128'(wr_err), 128'(1));
        readByte(8'hFF, 8'hA5, "id after write");
        readByte(8'hFE, 8'h00, "cnt after id write");
        checkOutput("id write regs_flat", regs_flat, '0);

        // Unmapped writes, and stickiness of wr_err across later good writes.
        doReset();
        applyStimulus(1'b1, 8'h00, 8'h5A, 1'b0);
        checkOutput("addr00 wr_err", 128'(wr_err), 128'(1));
        checkOutput("addr00 regs_flat", regs_flat, '0);
        doReset();
        applyStimulus(1'b1, 8'h40, 8'h5A, 1'b0);
        checkOutput("addr40 wr_err", 128'(wr_err), 128'(1));
        checkOutput("addr40 regs_flat", regs_flat, '0);
        readByte(8'h40, 8'h00, "addr40 read");
        applyStimulus(1'b1, 8'h05, 8'h66, 1'b0);
        modelWrite(8'h05, 8'h66);
        repeat (3) tick();
        checkOutput("wr_err sticky", 128'(wr_err), 128'(1));
        checkOutput("good write after err", regs_flat, expFlat);

        // 257 counted writes wrap the counter to 1.
        doReset();
        for (int i = 0; i < 257; i++) begin
            applyStimulus(1'b1, 8'(1 + i % 16), 8'(i), 1'b0);
            modelWrite(8'(1 + i % 16), 8'(i));
        end
        checkOutput("wrap regs_flat", regs_flat, expFlat);
        readByte(8'hFE, 8'h01, "counter wrap");

        // Same-edge write and load: old value shifts out, new value lands.
        doReset();
        applyStimulus(1'b1, 8'h02, 8'hAA, 1'b0);
        for (int i = 7; i >= 0; i--) expBits.push_back(1'((8'hAA >> i) & 8'h01));
        applyStimulus(1'b1, 8'h02, 8'h55, 1'b1);
        checkBits("same edge", 8);
        checkOutput("same edge reg1", regs_flat[15:8], 128'(8'h55));
        tick();
        readByte(8'hFE, 8'h02, "same edge count");

        // Back-to-back writes to one register.
        applyStimulus(1'b1, 8'h03, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h03, 8'h22, 1'b0);
        checkOutput("b2b reg2", regs_flat[23:16], 128'(8'h22));
        readByte(8'hFE, 8'h04, "b2b count");

        // Restart mid-byte: new byte_start reloads from the new address.
        applyStimulus(1'b1, 8'h01, 8'h3C, 1'b0);
        startByte(8'h01, 8'h3C);
        checkBits("abort", 3);
        expBits.delete();
        readByte(8'hFF, 8'hA5, "restart");

        // Asynchronous reset in the middle of a byte.
        doReset();
        applyStimulus(1'b1, 8'h01, 8'h3C, 1'b0);
        startByte(8'h01, 8'h3C);
        checkBits("pre reset", 3);
        rstn = 1'b0;
        #1;
        checkOutput("mid reset poci", 128'(poci), 128'(0));
        checkOutput("mid reset busy", 128'(busy), 128'(0));
        checkOutput("mid reset regs", regs_flat, '0);
        checkOutput("mid reset wr_err", 128'(wr_err), 128'(0));
        expBits.delete();
        @(negedge sclk);
        rstn = 1'b1;
        readByte(8'h01, 8'h00, "post reset reg0");
        applyStimulus(1'b1, 8'h01, 8'h5A, 1'b0);
        readByte(8'h01, 8'h5A, "post reset fresh");
        readByte(8'hFE, 8'h01, "post reset count");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
